// File: rtl/ex_mem_reg_if.sv
// EX->MEM pipeline register bus: E-stage inputs, stall/flush controls, M-stage outputs.
// The master side is the pipeline driving EX results; the slave side is the register.
interface ex_mem_reg_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              stallM;
  logic              flushM;
  logic              validE;
  logic [DATA_W-1:0] aluResultE;
  logic [DATA_W-1:0] writeDataE;
  logic [DATA_W-1:0] pcPlus4E;
  logic [RD_W-1:0]   rdE;
  logic              regWriteE;
  logic              memReadE;
  logic              memWriteE;
  logic [1:0]        resultSrcE;
  logic [2:0]        addressingModeE;

  logic              validM;
  logic              regWriteM;
  logic              memReadM;
  logic              memWriteM;
  logic [DATA_W-1:0] aluResultM;
  logic [DATA_W-1:0] writeDataM;
  logic [DATA_W-1:0] pcPlus4M;
  logic [RD_W-1:0]   rdM;
  logic [1:0]        resultSrcM;
  logic [2:0]        addressingModeM;
  logic              misalignM;

  modport master (
    output stallM, flushM, validE, aluResultE, writeDataE, pcPlus4E, rdE,
           regWriteE, memReadE, memWriteE, resultSrcE, addressingModeE,
    input  validM, regWriteM, memReadM, memWriteM, aluResultM, writeDataM,
           pcPlus4M, rdM, resultSrcM, addressingModeM, misalignM
  );

  modport slave (
    input  stallM, flushM, validE, aluResultE, writeDataE, pcPlus4E, rdE,
           regWriteE, memReadE, memWriteE, resultSrcE, addressingModeE,
    output validM, regWriteM, memReadM, memWriteM, aluResultM, writeDataM,
           pcPlus4M, rdM, resultSrcM, addressingModeM, misalignM
  );
endinterface

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with flush-over-stall priority and qualified control bits.
// Define EXMEM_MISALIGN_CHECK_EN to flag and squash misaligned word/half loads and stores.
module ex_mem_reg #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input logic          clk,
  input logic          rst,
  ex_mem_reg_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              misalign;
    logic [RD_W-1:0]   rd;
    logic [1:0]        result_src;
    logic [2:0]        mode;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] pc4;
  } stage_t;

  stage_t r_m;
  stage_t w_cap;
  stage_t w_next;
  logic   w_mem;
  logic   w_mis;

  assign w_mem = bus.validE & (bus.memReadE | bus.memWriteE);

`ifdef EXMEM_MISALIGN_CHECK_EN
  // Mode bits [1:0] encode size for both signed and unsigned variants.
  assign w_mis = w_mem &
                 (((bus.addressingModeE[1:0] == 2'b10) && (bus.aluResultE[1:0] != 2'b00)) ||
                  ((bus.addressingModeE[1:0] == 2'b01) && bus.aluResultE[0]));
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_cap            = '0;
    w_cap.valid      = bus.validE;
    w_cap.reg_write  = bus.regWriteE & bus.validE & ~w_mis;
    w_cap.mem_read   = bus.memReadE  & bus.validE & ~w_mis;
    w_cap.mem_write  = bus.memWriteE & bus.validE & ~w_mis;
    w_cap.misalign   = w_mis;
    // A non-writing stage carries rd=0 so forwarding compares never hit it.
    w_cap.rd         = w_cap.reg_write ? bus.rdE : '0;
    w_cap.result_src = bus.resultSrcE;
    w_cap.mode       = bus.addressingModeE;
    w_cap.alu        = bus.aluResultE;
    w_cap.wdata      = bus.writeDataE;
    w_cap.pc4        = bus.pcPlus4E;
  end

  always_comb begin
    w_next = w_cap;
    if (bus.flushM)      w_next = '0;
    else if (bus.stallM) w_next = r_m;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_m <= '0;
    else      r_m <= w_next;
  end

  assign bus.validM          = r_m.valid;
  assign bus.regWriteM       = r_m.reg_write;
  assign bus.memReadM        = r_m.mem_read;
  assign bus.memWriteM       = r_m.mem_write;
  assign bus.misalignM       = r_m.misalign;
  assign bus.rdM             = r_m.rd;
  assign bus.resultSrcM      = r_m.result_src;
  assign bus.addressingModeM = r_m.mode;
  assign bus.aluResultM      = r_m.alu;
  assign bus.writeDataM      = r_m.wdata;
  assign bus.pcPlus4M        = r_m.pc4;

endmodule
